cam_capture_v2: RTL and testbench
=================================

Name: cam_capture_v2

Overview:
- Parametrised successor to the 8-bit camera pixel capture stage, running in the camera pclk domain ahead of the frame-buffer write logic.
- Pairs bus bytes into 16-bit pixels and converts them to 24-bit RGB according to a runtime format mode.
- Applies a crop window and frame decimation, and emits a stream with valid, start-of-frame and end-of-line markers plus line/frame length error flags.

Parameters:
IN_W, 8, camera data bus width (bytes per pixel fixed at 2)
H_ACTIVE, 640, expected pixels per href line
V_ACTIVE, 480, expected lines per frame
CNT_W, 11, width of x/y counters and crop bounds

Ports:
pclk  in  1  camera pixel clock; all logic on rising edge
rst  in  1  asynchronous active-high reset
vsync  in  1  camera frame sync, high between frames
href  in  1  camera line valid
d  in  IN_W  camera data byte
mode  in  2  00 RGB565, 01 RGB555, 10 Y-only grey (YUV422), 11 raw {8'b0, pixel}
swap_bytes  in  1  0: first byte is MSB; 1: first byte is LSB
frame_skip  in  2  keep 1 of every frame_skip+1 frames
crop_x0, crop_x1  in  CNT_W  column window [x0, x1)
crop_y0, crop_y1  in  CNT_W  row window [y0, y1)
dout  out  24  pixel {R8,G8,B8}
data_valid  out  1  dout valid, one cycle per emitted pixel
sof  out  1  with first emitted pixel of frame
eol  out  1  with last emitted pixel of line (x == crop_x1-1)
x_cnt, y_cnt  out  CNT_W  coordinates of the pixel on dout
frame_cnt  out  8  accepted-frame count, wraps 255->0
line_err  out  1  one-cycle pulse on a bad line
frame_err  out  1  one-cycle pulse on a bad frame

Behaviour:
- Reset: all outputs 0; state WAIT_SYNC; counters 0; skip counter 0.
- Input registers: vsync, href and d are registered once. All edge detection uses the registered copies.
- State WAIT_SYNC:
  - Discard everything until a vsync falling edge, so a partial frame after reset is never emitted.
  - On that edge, latch mode, swap_bytes, frame_skip and the crop bounds into shadow registers; these stay fixed for the whole frame.
  - Then evaluate the skip counter:
    - skip counter == 0: go to FRAME, frame_cnt++, reload skip counter with frame_skip.
    - otherwise: decrement skip counter, go to SKIP.
- State SKIP: ignore bytes; return to WAIT_SYNC on vsync rising edge.
- State FRAME (href low): on href rising edge go to LINE; byte phase = 0, x = 0.
- State LINE, byte handling:
  - Each href-high cycle toggles the byte phase.
  - Phase 1 completes a pixel {b0,b1}, or {b1,b0} when swap_bytes = 1.
- State LINE, pixel output:
  - The pixel is registered to dout with data_valid = 1 two pclk after the edge where the second byte was on d.
  - Emit only if crop_x0 <= x < crop_x1 and crop_y0 <= y < crop_y1.
  - x increments per completed pixel regardless of crop.
- State LINE, end of line: on href falling edge go back to FRAME and y++.
  - Pulse line_err if the pixel count != H_ACTIVE or an odd byte was left dangling; a dangling byte is dropped.
- Frame end (FRAME or LINE, vsync rising edge): go to WAIT_SYNC.
  - Pulse frame_err if line count != V_ACTIVE.
  - If the edge arrives inside LINE, abort the line: no eol, line_err pulse.
- Formats:
  - RGB565: {p[15:11],3'b0, p[10:5],2'b0, p[4:0],3'b0}.
  - RGB555: {p[14:10],3'b0, p[9:5],3'b0, p[4:0],3'b0}.
  - Grey: Y = p[15:8], dout = {Y,Y,Y}.
  - Raw: {8'b0, p}.
- dout holds its last value while data_valid = 0; it is never zeroed between pixels.
- sof and eol are only asserted together with data_valid.
- sof fires once per accepted frame, on the first emitted pixel.
- An empty crop window (x0 >= x1 or y0 >= y1) emits nothing, but the error checks still run.
- x and y saturate at 2^CNT_W-1.
- Mid-operation reset: immediate return to reset values; the next frame needs a fresh vsync falling edge.

Test Plan:
- Reset released mid-frame, then a full 4x2 frame (H_ACTIVE=4, V_ACTIVE=2, full crop) -> no output until vsync falls; the second frame gives 8 valids, sof on (0,0), eol at x=3, frame_cnt = 1.
- RGB565 bytes 0xF8,0x1F -> dout 0xF800F8. Same with swap_bytes = 1 (bytes 0x1F,0xF8) -> 0xF800F8. Grey bytes 0x80,0x10 -> 0x808080. Valid exactly 2 pclk after the second byte.
- Crop x0=1, x1=3, y0=1, y1=2 on a 4x2 frame -> 2 valids at (1,1),(2,1); sof on (1,1); eol on (2,1).
- frame_skip = 2 over 6 frames -> frames 1 and 4 emitted; frame_cnt 1, then 2.
- Line with 7 bytes (3 pixels + dangling) -> 3 valids, line_err pulse at href fall. Only 1 line before vsync rises -> frame_err pulse.
- vsync rising while href high mid-line -> no eol, line_err pulse, state WAIT_SYNC; a mode change mid-frame takes effect only from the next frame.

Source files
------------

// File: rtl/cam_capture_v2.sv
// Camera capture stage: pairs bus bytes into 16-bit pixels, converts to RGB888,
// crops and decimates frames, and flags malformed lines and frames.
module cam_capture_v2 #(
  parameter int IN_W     = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 11
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             href,
  input  logic [IN_W-1:0]  d,
  input  logic [1:0]       mode,
  input  logic             swap_bytes,
  input  logic [1:0]       frame_skip,
  input  logic [CNT_W-1:0] crop_x0,
  input  logic [CNT_W-1:0] crop_x1,
  input  logic [CNT_W-1:0] crop_y0,
  input  logic [CNT_W-1:0] crop_y1,
  output logic [23:0]      dout,
  output logic             data_valid,
  output logic             sof,
  output logic             eol,
  output logic [CNT_W-1:0] x_cnt,
  output logic [CNT_W-1:0] y_cnt,
  output logic [7:0]       frame_cnt,
  output logic             line_err,
  output logic             frame_err
);

  typedef enum logic [1:0] {WAIT_SYNC, SKIP, FRAME, LINE} state_t;

  state_t           state_q, state_d;
  logic             vsync_q, vsync_p_q, href_q, href_p_q;
  logic [IN_W-1:0]  d_q, b0_q, b0_d;
  logic [1:0]       sh_mode_q, sh_mode_d, skip_q, skip_d;
  logic             sh_swap_q, sh_swap_d, phase_q, phase_d, sof_pend_q, sof_pend_d;
  logic [CNT_W-1:0] sh_x0_q, sh_x0_d, sh_x1_q, sh_x1_d, sh_y0_q, sh_y0_d, sh_y1_q, sh_y1_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             p1_valid_q, p1_valid_d, p1_sof_q, p1_sof_d, p1_eol_q, p1_eol_d;
  logic [23:0]      p1_rgb_q, p1_rgb_d, dout_q, dout_d;
  logic [CNT_W-1:0] p1_x_q, p1_x_d, p1_y_q, p1_y_d, xo_q, xo_d, yo_q, yo_d;
  logic             dv_q, dv_d, sof_q, sof_d, eol_q, eol_d;
  logic             line_err_q, line_err_d, frame_err_q, frame_err_d;

  logic             vs_rise, vs_fall, hr_rise, hr_fall, in_crop;
  logic [2*IN_W-1:0] pix;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [23:0] to_rgb(input logic [1:0] m, input logic [15:0] p);
    logic [23:0] r;
    case (m)
      2'b00:   r = {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
      2'b01:   r = {p[14:10], 3'b000, p[9:5], 3'b000, p[4:0], 3'b000};
      2'b10:   r = {p[15:8], p[15:8], p[15:8]};
      default: r = {8'h00, p};
    endcase
    return r;
  endfunction

  assign vs_rise = vsync_q & ~vsync_p_q;
  assign vs_fall = ~vsync_q & vsync_p_q;
  assign hr_rise = href_q & ~href_p_q;
  assign hr_fall = ~href_q & href_p_q;
  assign pix     = sh_swap_q ? {d_q, b0_q} : {b0_q, d_q};
  assign in_crop = (x_q >= sh_x0_q) && (x_q < sh_x1_q) && (y_q >= sh_y0_q) && (y_q < sh_y1_q);

  always_comb begin
    state_d     = state_q;
    sh_mode_d   = sh_mode_q;
    sh_swap_d   = sh_swap_q;
    sh_x0_d     = sh_x0_q;
    sh_x1_d     = sh_x1_q;
    sh_y0_d     = sh_y0_q;
    sh_y1_d     = sh_y1_q;
    skip_d      = skip_q;
    frame_cnt_d = frame_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = phase_q;
    b0_d        = b0_q;
    sof_pend_d  = sof_pend_q;
    p1_valid_d  = 1'b0;
    p1_sof_d    = 1'b0;
    p1_eol_d    = 1'b0;
    p1_rgb_d    = p1_rgb_q;
    p1_x_d      = p1_x_q;
    p1_y_d      = p1_y_q;
    line_err_d  = 1'b0;
    frame_err_d = 1'b0;
    // Output stage: dout and coordinates hold between pixels.
    dv_d   = p1_valid_q;
    sof_d  = p1_sof_q;
    eol_d  = p1_eol_q;
    dout_d = p1_valid_q ? p1_rgb_q : dout_q;
    xo_d   = p1_valid_q ? p1_x_q : xo_q;
    yo_d   = p1_valid_q ? p1_y_q : yo_q;

    case (state_q)
      WAIT_SYNC: begin
        if (vs_fall) begin
          sh_mode_d = mode;
          sh_swap_d = swap_bytes;
          sh_x0_d   = crop_x0;
          sh_x1_d   = crop_x1;
          sh_y0_d   = crop_y0;
          sh_y1_d   = crop_y1;
          y_d       = '0;
          if (skip_q == 2'd0) begin
            state_d     = FRAME;
            frame_cnt_d = frame_cnt_q + 8'd1;
            skip_d      = frame_skip;
            sof_pend_d  = 1'b1;
          end else begin
            state_d = SKIP;
            skip_d  = skip_q - 2'd1;
          end
        end
      end
      SKIP: begin
        if (vs_rise) state_d = WAIT_SYNC;
      end
      FRAME: begin
        if (vs_rise) begin
          state_d     = WAIT_SYNC;
          frame_err_d = (y_q != CNT_W'(V_ACTIVE));
        end else if (hr_rise) begin
          // The rising-edge cycle already carries the first byte of the line.
          state_d = LINE;
          x_d     = '0;
          b0_d    = d_q;
          phase_d = 1'b1;
        end
      end
      LINE: begin
        if (vs_rise) begin
          state_d     = WAIT_SYNC;
          line_err_d  = 1'b1;
          frame_err_d = (y_q != CNT_W'(V_ACTIVE));
        end else if (hr_fall) begin
          state_d    = FRAME;
          line_err_d = (x_q != CNT_W'(H_ACTIVE)) || phase_q;
          y_d        = sat_inc(y_q);
        end else if (href_q) begin
          if (!phase_q) begin
            b0_d    = d_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            x_d     = sat_inc(x_q);
            if (in_crop) begin
              p1_valid_d = 1'b1;
              p1_rgb_d   = to_rgb(sh_mode_q, pix[15:0]);
              p1_x_d     = x_q;
              p1_y_d     = y_q;
              p1_eol_d   = (x_q == sh_x1_q - CNT_W'(1));
              p1_sof_d   = sof_pend_q;
              sof_pend_d = 1'b0;
            end
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_SYNC;
      vsync_q <= 1'b0; vsync_p_q <= 1'b0; href_q <= 1'b0; href_p_q <= 1'b0;
      d_q <= '0; b0_q <= '0; phase_q <= 1'b0; sof_pend_q <= 1'b0;
      sh_mode_q <= '0; sh_swap_q <= 1'b0; skip_q <= '0;
      sh_x0_q <= '0; sh_x1_q <= '0; sh_y0_q <= '0; sh_y1_q <= '0;
      x_q <= '0; y_q <= '0; frame_cnt_q <= '0;
      p1_valid_q <= 1'b0; p1_sof_q <= 1'b0; p1_eol_q <= 1'b0;
      p1_rgb_q <= '0; p1_x_q <= '0; p1_y_q <= '0;
      dout_q <= '0; dv_q <= 1'b0; sof_q <= 1'b0; eol_q <= 1'b0; xo_q <= '0; yo_q <= '0;
      line_err_q <= 1'b0; frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync; vsync_p_q <= vsync_q; href_q <= href; href_p_q <= href_q;
      d_q <= d; b0_q <= b0_d; phase_q <= phase_d; sof_pend_q <= sof_pend_d;
      sh_mode_q <= sh_mode_d; sh_swap_q <= sh_swap_d; skip_q <= skip_d;
      sh_x0_q <= sh_x0_d; sh_x1_q <= sh_x1_d; sh_y0_q <= sh_y0_d; sh_y1_q <= sh_y1_d;
      x_q <= x_d; y_q <= y_d; frame_cnt_q <= frame_cnt_d;
      p1_valid_q <= p1_valid_d; p1_sof_q <= p1_sof_d; p1_eol_q <= p1_eol_d;
      p1_rgb_q <= p1_rgb_d; p1_x_q <= p1_x_d; p1_y_q <= p1_y_d;
      dout_q <= dout_d; dv_q <= dv_d; sof_q <= sof_d; eol_q <= eol_d; xo_q <= xo_d; yo_q <= yo_d;
      line_err_q <= line_err_d; frame_err_q <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign data_valid = dv_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign x_cnt      = xo_q;
  assign y_cnt      = yo_q;
  assign frame_cnt  = frame_cnt_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_cam_capture_v2.sv
// Bench for cam_capture_v2 on a 4x2 frame geometry: drivers push expected pixels
// and error pulses (with their due cycle) into queues; a negedge monitor checks them.
module tb_cam_capture_v2;
  localparam int CNT_W = 11;
  localparam int H_ACT = 4;
  localparam int V_ACT = 2;
  localparam int EW    = 88;

  logic             pclk = 1'b0;
  logic             rst, vsync, href, swap_bytes;
  logic [7:0]       d;
  logic [1:0]       mode, frame_skip;
  logic [CNT_W-1:0] crop_x0, crop_x1, crop_y0, crop_y1;
  logic [23:0]      dout;
  logic             data_valid, sof, eol, line_err, frame_err;
  logic [CNT_W-1:0] x_cnt, y_cnt;
  logic [7:0]       frame_cnt;

  cam_capture_v2 #(.IN_W(8), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .CNT_W(CNT_W)) dut (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .mode(mode),
    .swap_bytes(swap_bytes), .frame_skip(frame_skip),
    .crop_x0(crop_x0), .crop_x1(crop_x1), .crop_y0(crop_y0), .crop_y1(crop_y1),
    .dout(dout), .data_valid(data_valid), .sof(sof), .eol(eol),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_cnt(frame_cnt),
    .line_err(line_err), .frame_err(frame_err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 pclk = ~pclk;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            lerr_q[$];
  int            ferr_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  // Bench-side frame model
  int          skip_m = 0;
  logic [7:0]  fc_m = 8'd0;
  bit          acc = 1'b0, sof_pend_m = 1'b0;
  int          y_m = 0;
  logic [1:0]  sh_mode = 2'd0;
  bit          sh_swap = 1'b0;
  int          sx0 = 0, sx1 = 0, sy0 = 0, sy1 = 0;
  bit          vary = 1'b1, use_hand = 1'b0;
  logic [23:0] hand_rgb = 24'h0;
  logic [7:0]  pat0 = 8'h00, pat1 = 8'h00;
  int          mid_mode = -1;

  function automatic logic [23:0] rgb_m(input logic [1:0] m, input logic [15:0] p);
    logic [23:0] r;
    case (m)
      2'd0:    r = {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
      2'd1:    r = {p[14:10], 3'b000, p[9:5], 3'b000, p[4:0], 3'b000};
      2'd2:    r = {p[15:8], p[15:8], p[15:8]};
      default: r = {8'h00, p};
    endcase
    return r;
  endfunction

  function automatic logic [EW-1:0] mk(input int c, input logic [7:0] fc, input int x, input int y,
                                       input logic e, input logic s, input logic [23:0] rgb);
    return {32'(c), fc, 11'(x), 11'(y), e, s, rgb};
  endfunction

  function automatic logic [7:0] byte_val(input int i, input int y);
    if (!vary) return (i % 2 == 0) ? pat0 : pat1;
    if (i % 2 == 0) return 8'(16 * y + i / 2);
    return 8'(8'hA0 + i / 2);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drv(input logic v, input logic h, input logic [7:0] b);
    @(negedge pclk);
    vsync = v; href = h; d = b;
  endtask

  task automatic drive_bytes(input int nb);
    logic [7:0] b, b0;
    int px;
    b0 = 8'h00;
    for (int i = 0; i < nb; i++) begin
      b = byte_val(i, y_m);
      drv(1'b0, 1'b1, b);
      if (i % 2 == 0) b0 = b;
      else begin
        px = i / 2;
        if (acc && px >= sx0 && px < sx1 && y_m >= sy0 && y_m < sy1) begin
          exp_q.push_back(mk(cyc + 3, fc_m, px, y_m, px == sx1 - 1, sof_pend_m,
                             use_hand ? hand_rgb : rgb_m(sh_mode, sh_swap ? {b, b0} : {b0, b})));
          sof_pend_m = 1'b0;
        end
      end
    end
  endtask

  // Starts with vsync high already applied; ends with vsync high.
  task automatic send_frame(input int n_lines, input int nb, input int abort_nb);
    drv(1'b0, 1'b0, 8'h00);
    if (skip_m == 0) begin
      acc = 1'b1; fc_m = fc_m + 8'd1; skip_m = int'(frame_skip); sof_pend_m = 1'b1;
    end else begin
      acc = 1'b0; skip_m = skip_m - 1;
    end
    sh_mode = mode; sh_swap = swap_bytes;
    sx0 = int'(crop_x0); sx1 = int'(crop_x1); sy0 = int'(crop_y0); sy1 = int'(crop_y1);
    y_m = 0;
    drv(1'b0, 1'b0, 8'h00);
    drv(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < n_lines; l++) begin
      if (l == n_lines - 1 && abort_nb >= 0) begin
        drive_bytes(abort_nb);
        drv(1'b1, 1'b1, 8'h55);
        if (acc) begin
          lerr_q.push_back(cyc + 2);
          if (y_m != V_ACT) ferr_q.push_back(cyc + 2);
        end
        drv(1'b1, 1'b0, 8'h00);
      end else begin
        drive_bytes(nb);
        drv(1'b0, 1'b0, 8'h00);
        if (acc && nb != 2 * H_ACT) lerr_q.push_back(cyc + 2);
        y_m++;
        drv(1'b0, 1'b0, 8'h00);
        drv(1'b0, 1'b0, 8'h00);
      end
      if (l == 0 && mid_mode >= 0) mode = 2'(mid_mode);
    end
    if (abort_nb < 0) begin
      drv(1'b1, 1'b0, 8'h00);
      if (acc && y_m != V_ACT) ferr_q.push_back(cyc + 2);
    end
    repeat (3) drv(1'b1, 1'b0, 8'h00);
    n_cmp++;
    if (frame_cnt !== fc_m) begin
      n_bad++;
      $display("FAIL frame_cnt got %0d want %0d", frame_cnt, fc_m);
    end
  endtask

  task automatic check_reset(input string name);
    n_cmp++;
    if ({dout, data_valid, sof, eol, x_cnt, y_cnt, frame_cnt, line_err, frame_err} !== '0) begin
      n_bad++;
      $display("FAIL %s outputs not zero: dout=%h dv=%b sof=%b eol=%b x=%0d y=%0d fc=%0d le=%b fe=%b",
               name, dout, data_valid, sof, eol, x_cnt, y_cnt, frame_cnt, line_err, frame_err);
    end
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_e, mon_a;
  logic [23:0]   hold_rgb = 24'h0;
  bit            chk_hold = 1'b0;
  bit            lexp, fexp;

  always @(negedge pclk) begin
    if (exp_q.size() > 0 && exp_q[0][87:56] == 32'(cyc)) begin
      mon_e = exp_q.pop_front();
      mon_a = {32'(cyc), frame_cnt, x_cnt, y_cnt, eol, sof, dout};
      n_cmp++;
      if (data_valid !== 1'b1 || mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL pixel dv=%b got {cyc,fc,x,y,eol,sof,rgb}=%h want %h", data_valid, mon_a, mon_e);
      end
      hold_rgb = mon_e[23:0];
      chk_hold = 1'b1;
    end else if (data_valid || sof || eol) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_valid cycle %0d dv=%b dout=%h sof=%b eol=%b", cyc, data_valid, dout, sof, eol);
    end else if (chk_hold) begin
      chk_hold = 1'b0;
      n_cmp++;
      if (dout !== hold_rgb) begin
        n_bad++;
        $display("FAIL dout_hold got %h want %h", dout, hold_rgb);
      end
    end
    lexp = (lerr_q.size() > 0 && lerr_q[0] == cyc);
    if (lexp || line_err) begin
      n_cmp++;
      if (lexp) lerr_q.delete(0);
      if (line_err !== lexp) begin
        n_bad++;
        $display("FAIL line_err cycle %0d got %b want %b", cyc, line_err, lexp);
      end
    end
    fexp = (ferr_q.size() > 0 && ferr_q[0] == cyc);
    if (fexp || frame_err) begin
      n_cmp++;
      if (fexp) ferr_q.delete(0);
      if (frame_err !== fexp) begin
        n_bad++;
        $display("FAIL frame_err cycle %0d got %b want %b", cyc, frame_err, fexp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b1; d = 8'h3C;
    mode = 2'd3; swap_bytes = 1'b0; frame_skip = 2'd0;
    crop_x0 = 11'd0; crop_x1 = 11'd4; crop_y0 = 11'd0; crop_y1 = 11'd2;
    repeat (3) @(negedge pclk);
    check_reset("reset");
    rst = 1'b0;

    // Reset released mid-frame: the partial frame must be discarded.
    for (int i = 0; i < 6; i++) drv(1'b0, 1'b1, 8'(i + 1));
    repeat (2) drv(1'b0, 1'b0, 8'h00);
    repeat (3) drv(1'b1, 1'b0, 8'h00);

    // Full 4x2 raw frame
    vary = 1'b1;
    send_frame(2, 8, -1);

    // Formats with hand-computed colours
    vary = 1'b0; use_hand = 1'b1;
    mode = 2'd0; swap_bytes = 1'b0; pat0 = 8'hF8; pat1 = 8'h1F; hand_rgb = 24'hF800F8;
    send_frame(2, 8, -1);
    swap_bytes = 1'b1; pat0 = 8'h1F; pat1 = 8'hF8; hand_rgb = 24'hF800F8;
    send_frame(2, 8, -1);
    mode = 2'd2; swap_bytes = 1'b0; pat0 = 8'h80; pat1 = 8'h10; hand_rgb = 24'h808080;
    send_frame(2, 8, -1);
    mode = 2'd1; pat0 = 8'h7C; pat1 = 8'h00; hand_rgb = 24'hF80000;
    send_frame(2, 8, -1);
    use_hand = 1'b0; vary = 1'b1; mode = 2'd3;

    // Crop window, then an empty window where only error checks fire
    crop_x0 = 11'd1; crop_x1 = 11'd3; crop_y0 = 11'd1; crop_y1 = 11'd2;
    send_frame(2, 8, -1);
    crop_x0 = 11'd2; crop_x1 = 11'd2;
    send_frame(2, 7, -1);
    crop_x0 = 11'd0; crop_x1 = 11'd4; crop_y0 = 11'd0; crop_y1 = 11'd2;

    // Decimation: keep 1 of every 3 frames
    frame_skip = 2'd2;
    repeat (6) send_frame(2, 8, -1);
    frame_skip = 2'd0;

    // Dangling byte and short frame
    send_frame(1, 7, -1);

    // Abort mid-line with a mode change that must wait for the next frame
    mid_mode = 2;
    send_frame(2, 8, 3);
    mid_mode = -1;
    repeat (4) drv(1'b1, 1'b1, 8'hEE);
    repeat (2) drv(1'b1, 1'b0, 8'h00);
    send_frame(2, 8, -1);

    // Mid-operation reset after a frame has been accepted
    drv(1'b0, 1'b0, 8'h00);
    repeat (2) drv(1'b0, 1'b0, 8'h00);
    @(negedge pclk); rst = 1'b1;
    @(negedge pclk);
    check_reset("mid_reset");
    rst = 1'b0; fc_m = 8'd0; skip_m = 0;
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 8'(8'h40 + i));
    repeat (2) drv(1'b0, 1'b0, 8'h00);
    repeat (3) drv(1'b1, 1'b0, 8'h00);
    send_frame(2, 8, -1);

    repeat (6) drv(1'b1, 1'b0, 8'h00);
    n_cmp++;
    if (exp_q.size() + lerr_q.size() + ferr_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover expectations pix=%0d lerr=%0d ferr=%0d want 0",
               exp_q.size(), lerr_q.size(), ferr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
